// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: producer kinds, forwarding selects,
// pipeline stage encodings and the per-register scoreboard entry.
package hazard_pkg;

    // Producer class decoded in ID; the reserved code behaves like an ALU op
    typedef enum logic [1:0] {
        KindAlu    = 2'b00,
        KindLoad   = 2'b01,
        KindMulDiv = 2'b10,
        KindRsvd   = 2'b11
    } id_kind_e;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Stage a tracked producer currently occupies
    localparam logic [1:0] STG_NONE = 2'd0;
    localparam logic [1:0] STG_EX   = 2'd1;
    localparam logic [1:0] STG_MEM  = 2'd2;
    localparam logic [1:0] STG_WB   = 2'd3;

    typedef struct packed {
        logic       busy;
        logic [1:0] stage;
        logic       is_load;
    } scb_entry_t;

    // Multiply/divide occupancy FSM
    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StMdBusy = 1'b1
    } md_state_e;

    // EX operand select for a consumer that hits a busy entry. A load still in
    // EX has no data yet; that case is a stall and is resolved separately.
    function automatic logic [1:0] fwd_sel(input scb_entry_t e);
        logic [1:0] sel;
        sel = FWD_RF;
        case (e.stage)
            STG_EX:  sel = e.is_load ? FWD_RF : FWD_MEM;
            STG_MEM: sel = FWD_WB;
            default: sel = FWD_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX hazard interface between the pipeline datapath (master) and the
// hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned SCW  = 32
);
    import hazard_pkg::*;

    localparam int unsigned AW = $clog2(NREG);

    logic            id_valid_i;
    logic [AW-1:0]   id_rs1_addr_i;
    logic [AW-1:0]   id_rs2_addr_i;
    logic            id_is_rs1_i;
    logic            id_is_rs2_i;
    logic [AW-1:0]   id_rd_addr_i;
    logic            id_rd_wren_i;
    id_kind_e        id_kind_i;
    logic            ex_br_sel_i;

    logic            pc_enable_o;
    logic            id_enable_o;
    logic            ex_enable_o;
    logic            mem_enable_o;
    logic            wb_enable_o;
    logic            id_reset_no;
    logic            ex_reset_no;
    logic [1:0]      ex_fwd_a_o;
    logic [1:0]      ex_fwd_b_o;
    logic            id_fwd_rs1_o;
    logic            id_fwd_rs2_o;
    logic [SCW-1:0]  stall_cnt_o;

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_is_rs1_i, id_is_rs2_i,
        input  id_rd_addr_i, id_rd_wren_i, id_kind_i, ex_br_sel_i,
        output pc_enable_o, id_enable_o, ex_enable_o, mem_enable_o, wb_enable_o,
        output id_reset_no, ex_reset_no, ex_fwd_a_o, ex_fwd_b_o,
        output id_fwd_rs1_o, id_fwd_rs2_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_is_rs1_i, id_is_rs2_i,
        output id_rd_addr_i, id_rd_wren_i, id_kind_i, ex_br_sel_i,
        input  pc_enable_o, id_enable_o, ex_enable_o, mem_enable_o, wb_enable_o,
        input  id_reset_no, ex_reset_no, ex_fwd_a_o, ex_fwd_b_o,
        input  id_fwd_rs1_o, id_fwd_rs2_o, stall_cnt_o
    );

endinterface

// File: rtl/scb_entry_file.sv
// Scoreboard entry array: one entry per architectural register 1..NREG-1
// (x0 is never tracked). One issue write port, a global advance strobe and
// two combinational lookup ports.
module scb_entry_file
    import hazard_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_ni,
    input  logic                    i_issue,
    input  logic [$clog2(NREG)-1:0] i_issue_rd,
    input  logic                    i_issue_load,
    input  logic                    i_advance,
    input  logic [$clog2(NREG)-1:0] i_lk_a_addr,
    output scb_entry_t              o_lk_a,
    input  logic [$clog2(NREG)-1:0] i_lk_b_addr,
    output scb_entry_t              o_lk_b
);

    localparam int unsigned AW = $clog2(NREG);

    scb_entry_t r_entries [1:NREG-1];
    scb_entry_t w_entries [1:NREG-1];

    // Next entry state: advance busy producers, drop them after WB; a new
    // issue to the same register overrides both advance and clear.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            w_entries[i] = r_entries[i];
            if (i_advance && r_entries[i].busy) begin
                if (r_entries[i].stage == STG_WB) begin
                    w_entries[i] = '0;
                end else begin
                    w_entries[i].stage = r_entries[i].stage + 2'd1;
                end
            end
            if (i_issue && (i_issue_rd == AW'(i))) begin
                w_entries[i].busy    = 1'b1;
                w_entries[i].stage   = STG_EX;
                w_entries[i].is_load = i_issue_load;
            end
        end
    end

    // Entry registers with synchronous clear
    always_ff @(posedge i_clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (!i_rst_ni) begin
                r_entries[i] <= '0;
            end else begin
                r_entries[i] <= w_entries[i];
            end
        end
    end

    // Lookup ports; address 0 always reads as an empty entry
    always_comb begin
        o_lk_a = '0;
        o_lk_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (i_lk_a_addr == AW'(i)) o_lk_a = r_entries[i];
            if (i_lk_b_addr == AW'(i)) o_lk_b = r_entries[i];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage in-order pipeline: tracks in-flight register
// producers, generates stage enables/flushes, EX forwarding selects, the
// WB-to-ID bypass and a saturating stall counter.
// Optional feature: define SCB_MULDIV_EN to add the multi-cycle MULDIV
// occupancy FSM (MD_BUSY state plus down-counter); without it MULDIV
// producers are handled exactly like ALU producers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned SCW    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_ni,
    hazard_scoreboard_if.slave  bus
);

    scb_entry_t     w_lk_a;
    scb_entry_t     w_lk_b;
    logic           w_hit_a;
    logic           w_hit_b;
    logic           w_lu_a;
    logic           w_lu_b;
    logic [1:0]     w_sel_a;
    logic [1:0]     w_sel_b;
    logic           w_md_busy;
    logic           w_br;
    logic           w_load_use;
    logic           w_issue;
    logic           w_issue_wr;
    logic           w_pc_en;
    logic           w_id_en;
    logic           w_ex_en;
    logic           w_mem_en;
    logic           w_wb_en;
    logic           w_id_rst_n;
    logic           w_ex_rst_n;
    logic [1:0]     r_ex_fwd_a;
    logic [1:0]     r_ex_fwd_b;
    logic [SCW-1:0] r_stall_cnt;

    scb_entry_file #(
        .NREG (NREG)
    ) u_entry_file (
        .i_clk        (i_clk),
        .i_rst_ni     (i_rst_ni),
        .i_issue      (w_issue_wr),
        .i_issue_rd   (bus.id_rd_addr_i),
        .i_issue_load (bus.id_kind_i == KindLoad),
        .i_advance    (w_ex_en),
        .i_lk_a_addr  (bus.id_rs1_addr_i),
        .o_lk_a       (w_lk_a),
        .i_lk_b_addr  (bus.id_rs2_addr_i),
        .o_lk_b       (w_lk_b)
    );

    // Per-source dependency decode against the scoreboard
    always_comb begin
        w_hit_a = bus.id_is_rs1_i && (bus.id_rs1_addr_i != '0) && w_lk_a.busy;
        w_hit_b = bus.id_is_rs2_i && (bus.id_rs2_addr_i != '0) && w_lk_b.busy;
        w_lu_a  = w_hit_a && (w_lk_a.stage == STG_EX) && w_lk_a.is_load;
        w_lu_b  = w_hit_b && (w_lk_b.stage == STG_EX) && w_lk_b.is_load;
        w_sel_a = w_hit_a ? fwd_sel(w_lk_a) : FWD_RF;
        w_sel_b = w_hit_b ? fwd_sel(w_lk_b) : FWD_RF;
    end

    // A resolved branch cannot coexist with MULDIV occupancy, so it is ignored there
    assign w_br       = bus.ex_br_sel_i && !w_md_busy;
    assign w_load_use = !w_md_busy && bus.id_valid_i && !bus.ex_br_sel_i && (w_lu_a || w_lu_b);

    // Stage enables and flushes: MULDIV freeze > branch flush > load-use bubble
    always_comb begin
        w_pc_en    = 1'b1;
        w_id_en    = 1'b1;
        w_ex_en    = 1'b1;
        w_mem_en   = 1'b1;
        w_wb_en    = 1'b1;
        w_id_rst_n = 1'b1;
        w_ex_rst_n = 1'b1;
        if (w_md_busy) begin
            w_pc_en  = 1'b0;
            w_id_en  = 1'b0;
            w_ex_en  = 1'b0;
            w_mem_en = 1'b0;
            w_wb_en  = 1'b0;
        end else if (w_br) begin
            w_id_rst_n = 1'b0;
            w_ex_rst_n = 1'b0;
        end else if (w_load_use) begin
            w_pc_en    = 1'b0;
            w_id_en    = 1'b0;
            w_ex_rst_n = 1'b0;
        end
    end

    assign w_issue    = bus.id_valid_i && w_id_en && !w_load_use && !w_br;
    assign w_issue_wr = w_issue && bus.id_rd_wren_i && (bus.id_rd_addr_i != '0);

`ifdef SCB_MULDIV_EN
    md_state_e r_state;
    md_state_e w_state_next;
    logic [3:0] r_md_cnt;
    logic [3:0] w_md_cnt_next;

    // MULDIV occupancy state and down-counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_ni) begin
            r_state  <= StRun;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Occupancy lasts MD_LAT-1 cycles after the issue cycle
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        unique case (r_state)
            StRun: begin
                if (w_issue && (bus.id_kind_i == KindMulDiv)) begin
                    w_state_next  = StMdBusy;
                    w_md_cnt_next = 4'(MD_LAT - 1);
                end
            end
            StMdBusy: begin
                if (r_md_cnt <= 4'd1) begin
                    w_state_next  = StRun;
                    w_md_cnt_next = '0;
                end else begin
                    w_md_cnt_next = r_md_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next  = StRun;
                w_md_cnt_next = '0;
            end
        endcase
    end

    assign w_md_busy = (r_state == StMdBusy);
`else
    assign w_md_busy = 1'b0;
`endif

    // EX forwarding selects follow the issuing instruction; bubbles and
    // flushes enter EX with regfile operands, a frozen pipe keeps its selects
    always_ff @(posedge i_clk) begin
        if (!i_rst_ni) begin
            r_ex_fwd_a <= FWD_RF;
            r_ex_fwd_b <= FWD_RF;
        end else if (!w_md_busy) begin
            r_ex_fwd_a <= w_issue ? w_sel_a : FWD_RF;
            r_ex_fwd_b <= w_issue ? w_sel_b : FWD_RF;
        end
    end

    // Saturating count of load-use and MULDIV stall cycles
    always_ff @(posedge i_clk) begin
        if (!i_rst_ni) begin
            r_stall_cnt <= '0;
        end else if ((w_load_use || w_md_busy) && (r_stall_cnt != {SCW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_enable_o  = w_pc_en;
    assign bus.id_enable_o  = w_id_en;
    assign bus.ex_enable_o  = w_ex_en;
    assign bus.mem_enable_o = w_mem_en;
    assign bus.wb_enable_o  = w_wb_en;
    assign bus.id_reset_no  = w_id_rst_n;
    assign bus.ex_reset_no  = w_ex_rst_n;
    assign bus.ex_fwd_a_o   = r_ex_fwd_a;
    assign bus.ex_fwd_b_o   = r_ex_fwd_b;
    assign bus.id_fwd_rs1_o = w_hit_a && (w_lk_a.stage == STG_WB);
    assign bus.id_fwd_rs2_o = w_hit_b && (w_lk_b.stage == STG_WB);
    assign bus.stall_cnt_o  = r_stall_cnt;

endmodule
